// File: rtl/memshare_regfile_loader.sv
// memshare_regfile_loader
//   Write-side master for the Type-0 (l1pa shift / shift delta / isGtr) register file of the
//   memShare scheduler. A valid/ready stream of page words is written to consecutive pages,
//   starting at start_page_i and wrapping from the last page back to page 0.
//
// Ports
//   sys_clk, rstn        clock, asynchronous active-low reset
//   load_start_i         1-cycle load request, sampled only while idle
//   start_page_i         first page written
//   page_cnt_i           number of pages to write (0..TYPE0_PAGE_NUM)
//   cfg_valid_i/ready_o  stream handshake; cfg_data_i word, cfg_last_i final word marker
//   regType0_waddr_o     register-file write address
//   regType0_wdata_o     register-file write data
//   regType0_we_o        register-file write enable (one cycle after word acceptance)
//   regType0_raddr_o     read-back address (verify build only, else 0)
//   regType0_rdata_i     read-back data (verify build only, else unused)
//   load_busy_o          high from accepted start until the done pulse
//   load_done_o          1-cycle completion pulse
//   load_err_o           sticky error, cleared by the next accepted start
//
// Build option
//   MEMSHARE_LOADER_VERIFY_EN: after the load, every written page is read back and the XOR of
//   the read data is compared with the XOR of the written words; a difference sets load_err_o.

module memshare_regfile_loader #(
  parameter int unsigned TYPE0_ADDR_BITWIDTH = 5,
  parameter int unsigned TYPE0_REG_BITWIDTH  = 7,
  parameter int unsigned TYPE0_PAGE_NUM      = 32,
  parameter int unsigned REGFILE_RD_CYCLE    = 1
) (
  input  logic                          sys_clk,
  input  logic                          rstn,
  input  logic                          load_start_i,
  input  logic [TYPE0_ADDR_BITWIDTH-1:0] start_page_i,
  input  logic [TYPE0_ADDR_BITWIDTH:0]   page_cnt_i,
  input  logic                          cfg_valid_i,
  input  logic [TYPE0_REG_BITWIDTH-1:0]  cfg_data_i,
  input  logic                          cfg_last_i,
  output logic                          cfg_ready_o,
  output logic [TYPE0_ADDR_BITWIDTH-1:0] regType0_waddr_o,
  output logic [TYPE0_REG_BITWIDTH-1:0]  regType0_wdata_o,
  output logic                          regType0_we_o,
  output logic [TYPE0_ADDR_BITWIDTH-1:0] regType0_raddr_o,
  input  logic [TYPE0_REG_BITWIDTH-1:0]  regType0_rdata_i,
  output logic                          load_busy_o,
  output logic                          load_done_o,
  output logic                          load_err_o
);

  localparam int unsigned AW = TYPE0_ADDR_BITWIDTH;
  localparam int unsigned RW = TYPE0_REG_BITWIDTH;
  localparam int unsigned CW = TYPE0_ADDR_BITWIDTH + 1;
  localparam logic [AW-1:0] LastPage = AW'(TYPE0_PAGE_NUM - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;     // pages still to be accepted
  logic          fin_q, fin_d;     // final word accepted, its write is in flight
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [RW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;

  logic start_bad, cnt_bad;

  function automatic logic [AW-1:0] next_page(input logic [AW-1:0] p);
    return (p == LastPage) ? '0 : p + AW'(1);
  endfunction

  // Widened compares keep the range checks valid for any parameterisation.
  assign start_bad = 32'(start_page_i) >= TYPE0_PAGE_NUM;
  assign cnt_bad   = 32'(page_cnt_i) > TYPE0_PAGE_NUM;

`ifdef MEMSHARE_LOADER_VERIFY_EN
  logic [RW-1:0]               csum_q, csum_d;       // XOR of written words
  logic [RW-1:0]               rd_csum_q, rd_csum_d; // XOR of read-back words
  logic [AW-1:0]               rd_start_q, rd_start_d;
  logic [AW-1:0]               rd_addr_q, rd_addr_d;
  logic [CW-1:0]               wr_num_q, wr_num_d;
  logic [CW-1:0]               rd_left_q, rd_left_d;
  logic [CW-1:0]               cap_left_q, cap_left_d;
  logic [REGFILE_RD_CYCLE-1:0] pipe_q, pipe_d;       // tracks reads in flight
  logic                        issue, capture;

  assign capture          = pipe_q[REGFILE_RD_CYCLE-1];
  assign regType0_raddr_o = rd_addr_q;
`else
  logic unused_rdata;
  assign unused_rdata     = ^regType0_rdata_i;
  assign regType0_raddr_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef MEMSHARE_LOADER_VERIFY_EN
    csum_d     = csum_q;
    rd_csum_d  = rd_csum_q;
    rd_start_d = rd_start_q;
    rd_addr_d  = rd_addr_q;
    wr_num_d   = wr_num_q;
    rd_left_d  = rd_left_q;
    cap_left_d = cap_left_q;
    issue      = 1'b0;
    pipe_d     = pipe_q << 1;
`endif

    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          err_d  = 1'b0;
          fin_d  = 1'b0;
          addr_d = start_page_i;
          cnt_d  = page_cnt_i;
`ifdef MEMSHARE_LOADER_VERIFY_EN
          csum_d     = '0;
          rd_csum_d  = '0;
          wr_num_d   = '0;
          rd_start_d = start_page_i;
`endif
          if (start_bad || cnt_bad) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (page_cnt_i == '0) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        if (fin_q) begin
          // The last write is on the bus this cycle; leave LOAD behind it.
          fin_d = 1'b0;
`ifdef MEMSHARE_LOADER_VERIFY_EN
          state_d    = StVerify;
          rd_addr_d  = rd_start_q;
          rd_left_d  = wr_num_q;
          cap_left_d = wr_num_q;
`else
          state_d = StDone;
`endif
        end else if (cfg_valid_i) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = cfg_data_i;
          addr_d  = next_page(addr_q);
          cnt_d   = cnt_q - CW'(1);
`ifdef MEMSHARE_LOADER_VERIFY_EN
          csum_d   = csum_q ^ cfg_data_i;
          wr_num_d = wr_num_q + CW'(1);
`endif
          if (cnt_q == CW'(1) || cfg_last_i) begin
            fin_d = 1'b1;
            // Marker ahead of the requested count means the stream was short.
            if (cnt_q != CW'(1)) err_d = 1'b1;
          end
        end
      end

`ifdef MEMSHARE_LOADER_VERIFY_EN
      StVerify: begin
        if (rd_left_q != '0) begin
          issue     = 1'b1;
          rd_addr_d = next_page(rd_addr_q);
          rd_left_d = rd_left_q - CW'(1);
        end
        if (capture) begin
          rd_csum_d  = rd_csum_q ^ regType0_rdata_i;
          cap_left_d = cap_left_q - CW'(1);
          if (cap_left_q == CW'(1)) begin
            state_d = StDone;
            if (rd_csum_d != csum_q) err_d = 1'b1;
          end
        end
      end
`endif

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase

`ifdef MEMSHARE_LOADER_VERIFY_EN
    pipe_d[0] = issue;
`endif
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef MEMSHARE_LOADER_VERIFY_EN
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      csum_q     <= '0;
      rd_csum_q  <= '0;
      rd_start_q <= '0;
      rd_addr_q  <= '0;
      wr_num_q   <= '0;
      rd_left_q  <= '0;
      cap_left_q <= '0;
      pipe_q     <= '0;
    end else begin
      csum_q     <= csum_d;
      rd_csum_q  <= rd_csum_d;
      rd_start_q <= rd_start_d;
      rd_addr_q  <= rd_addr_d;
      wr_num_q   <= wr_num_d;
      rd_left_q  <= rd_left_d;
      cap_left_q <= cap_left_d;
      pipe_q     <= pipe_d;
    end
  end
`endif

  assign cfg_ready_o      = (state_q == StLoad) && !fin_q;
  assign regType0_we_o    = we_q;
  assign regType0_waddr_o = waddr_q;
  assign regType0_wdata_o = wdata_q;
  assign load_busy_o      = (state_q != StIdle);
  assign load_done_o      = (state_q == StDone);
  assign load_err_o       = err_q;

endmodule

// File: tb/tb_memshare_regfile_loader.sv
module tb_memshare_regfile_loader;

  localparam int unsigned AW = 5;
  localparam int unsigned RW = 7;
  localparam int unsigned NP = 32;
  localparam int unsigned RD = 1;

  logic          sys_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] start_page = '0;
  logic [AW:0]   page_cnt = '0;
  logic          cfg_valid = 1'b0;
  logic [RW-1:0] cfg_data = '0;
  logic          cfg_last = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] waddr;
  logic [RW-1:0] wdata;
  logic          we;
  logic [AW-1:0] raddr;
  logic [RW-1:0] rdata_q;
  logic          load_busy, load_done, load_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  memshare_regfile_loader #(
    .TYPE0_ADDR_BITWIDTH(AW),
    .TYPE0_REG_BITWIDTH (RW),
    .TYPE0_PAGE_NUM     (NP),
    .REGFILE_RD_CYCLE   (RD)
  ) dut (
    .sys_clk         (sys_clk),
    .rstn            (rstn),
    .load_start_i    (load_start),
    .start_page_i    (start_page),
    .page_cnt_i      (page_cnt),
    .cfg_valid_i     (cfg_valid),
    .cfg_data_i      (cfg_data),
    .cfg_last_i      (cfg_last),
    .cfg_ready_o     (cfg_ready),
    .regType0_waddr_o(waddr),
    .regType0_wdata_o(wdata),
    .regType0_we_o   (we),
    .regType0_raddr_o(raddr),
    .regType0_rdata_i(rdata_q),
    .load_busy_o     (load_busy),
    .load_done_o     (load_done),
    .load_err_o      (load_err)
  );

  // Register-file model: registered read, optional corruption of page 2 on read-back.
  logic [RW-1:0] mem [NP];
  int unsigned   wr_count;
  logic          clr = 1'b1;
  logic          corrupt = 1'b0;

  always @(posedge sys_clk) begin
    if (clr) begin
      for (int i = 0; i < NP; i++) mem[i] <= 7'h7f;
      wr_count <= 0;
    end else if (we) begin
      mem[waddr] <= wdata;
      wr_count   <= wr_count + 1;
    end
    rdata_q <= mem[raddr] ^ ((corrupt && raddr == 5'd2) ? 7'h01 : 7'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] p, input logic [AW:0] c);
    load_start = 1'b1;
    start_page = p;
    page_cnt   = c;
    cyc();
    load_start = 1'b0;
  endtask

  // Presents one word and holds it until accepted; then checks the registered write.
  task automatic send_word(input logic [RW-1:0] d, input logic l, input logic [AW-1:0] a);
    logic acc;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = cfg_ready;
      cyc();
    end
    check("accept", 32'(acc), 32'd1);
    check("we", 32'(we), 32'd1);
    check("waddr", 32'(waddr), 32'(a));
    check("wdata", 32'(wdata), 32'(d));
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic gap();
    cyc();
    check("gap_we", 32'(we), 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!load_done && n < 100) begin
      cyc();
      n++;
    end
    check("done_seen", 32'(load_done), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    time t0;

    cyc();
    clr = 1'b0;
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    rstn = 1'b1;
    cyc();

    // Basic load of 4 pages from page 0.
    do_start(5'd0, 6'd4);
    check("t1_busy", 32'(load_busy), 32'd1);
    check("t1_ready", 32'(cfg_ready), 32'd1);
    send_word(7'h11, 1'b0, 5'd0);
    send_word(7'h22, 1'b0, 5'd1);
    send_word(7'h33, 1'b0, 5'd2);
    send_word(7'h44, 1'b1, 5'd3);
    wait_done(n);
`ifndef MEMSHARE_LOADER_VERIFY_EN
    check("t1_done_lat", 32'(n), 32'd1);
`endif
    check("t1_err", 32'(load_err), 32'd0);
    check("t1_cnt", wr_count, 32'd4);
    check("t1_m0", 32'(mem[0]), 32'h11);
    check("t1_m1", 32'(mem[1]), 32'h22);
    check("t1_m2", 32'(mem[2]), 32'h33);
    check("t1_m3", 32'(mem[3]), 32'h44);
    cyc();
    check("t1_done_pulse", 32'(load_done), 32'd0);
    check("t1_idle", 32'(load_busy), 32'd0);

    // Wrap from page 31 to page 0.
    do_start(5'd30, 6'd4);
    send_word(7'h01, 1'b0, 5'd30);
    send_word(7'h02, 1'b0, 5'd31);
    send_word(7'h03, 1'b0, 5'd0);
    send_word(7'h04, 1'b1, 5'd1);
    wait_done(n);
    check("t2_err", 32'(load_err), 32'd0);
    check("t2_cnt", wr_count, 32'd8);
    check("t2_m30", 32'(mem[30]), 32'h01);
    check("t2_m31", 32'(mem[31]), 32'h02);
    check("t2_m0", 32'(mem[0]), 32'h03);
    check("t2_m1", 32'(mem[1]), 32'h04);
    cyc();

    // Short stream: last marker on the 3rd of 5 words.
    do_start(5'd5, 6'd5);
    send_word(7'h0a, 1'b0, 5'd5);
    send_word(7'h0b, 1'b0, 5'd6);
    send_word(7'h0c, 1'b1, 5'd7);
    wait_done(n);
    check("t3_err", 32'(load_err), 32'd1);
    check("t3_cnt", wr_count, 32'd11);
    check("t3_m8", 32'(mem[8]), 32'h7f);
    cyc();
    check("t3_err_sticky", 32'(load_err), 32'd1);
    do_start(5'd10, 6'd1);
    check("t3_err_clr", 32'(load_err), 32'd0);
    send_word(7'h5a, 1'b1, 5'd10);
    wait_done(n);
    check("t3b_err", 32'(load_err), 32'd0);
    check("t3b_m10", 32'(mem[10]), 32'h5a);
    cyc();

    // Valid toggling, count reached without last, extra words ignored.
    do_start(5'd12, 6'd3);
    send_word(7'h31, 1'b0, 5'd12);
    gap();
    send_word(7'h32, 1'b0, 5'd13);
    gap();
    send_word(7'h33, 1'b0, 5'd14);
    cfg_valid = 1'b1;
    cfg_data  = 7'h55;
    wait_done(n);
    check("t4_err", 32'(load_err), 32'd0);
    cyc();
    cyc();
    check("t4_idle_ready", 32'(cfg_ready), 32'd0);
    check("t4_cnt", wr_count, 32'd15);
    check("t4_m12", 32'(mem[12]), 32'h31);
    check("t4_m13", 32'(mem[13]), 32'h32);
    check("t4_m14", 32'(mem[14]), 32'h33);
    check("t4_m15", 32'(mem[15]), 32'h7f);
    cfg_valid = 1'b0;

    // Zero page count: immediate done, no writes.
    do_start(5'd3, 6'd0);
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_busy", 32'(load_busy), 32'd1);
    check("t5_ready", 32'(cfg_ready), 32'd0);
    check("t5_err", 32'(load_err), 32'd0);
    cyc();
    check("t5_done_pulse", 32'(load_done), 32'd0);
    check("t5_cnt", wr_count, 32'd15);

    // Page count beyond the register file: done with error, no writes.
    do_start(5'd0, 6'd33);
    check("t6_done", 32'(load_done), 32'd1);
    check("t6_err", 32'(load_err), 32'd1);
    cyc();
    check("t6_cnt", wr_count, 32'd15);

    // Reset mid-load: first page written, second write aborted.
    do_start(5'd20, 6'd4);
    check("t7_err_clr", 32'(load_err), 32'd0);
    send_word(7'h61, 1'b0, 5'd20);
    send_word(7'h62, 1'b0, 5'd21);
    rstn = 1'b0;
    #1;
    check("t7_busy", 32'(load_busy), 32'd0);
    check("t7_we", 32'(we), 32'd0);
    check("t7_ready", 32'(cfg_ready), 32'd0);
    cyc();
    check("t7_m20", 32'(mem[20]), 32'h61);
    check("t7_m21", 32'(mem[21]), 32'h7f);
    rstn = 1'b1;
    cyc();

`ifdef MEMSHARE_LOADER_VERIFY_EN
    // Read-back verify, clean then with page 2 corrupted on read.
    clear_mem();
    corrupt = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      base = (pass == 0) ? 32'h10 : 32'h20;
      corrupt = (pass == 1);
      do_start(5'd0, 6'd4);
      t0 = $time;
      send_word(7'(base + 1), 1'b0, 5'd0);
      send_word(7'(base + 2), 1'b0, 5'd1);
      send_word(7'(base + 3), 1'b0, 5'd2);
      send_word(7'(base + 4), 1'b1, 5'd3);
      wait_done(n);
      check("v_lat", 32'(($time - t0) / 10), 32'(2 * 4 + RD + 1));
      check("v_err", 32'(load_err), 32'(pass));
      cyc();
    end
    corrupt = 1'b0;
`else
    clear_mem();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
